// File: rtl/satatrn_pkg.sv
// Shared definitions for the SATA transport TX data scheduler.
package satatrn_pkg;

  // FIS type byte of a Data FIS (host-to-device and device-to-host).
  localparam logic [7:0] FIS_DATA = 8'h46;

  // Scheduler states.
  typedef enum logic [2:0] {
    IDLE,     // no transfer open, waiting for activate + data
    HDR,      // Data FIS header sitting in the output register
    DATA,     // streaming payload dwords of the current FIS
    WAIT,     // last dword handed off, waiting for link completion
    WAITACT,  // transfer still open, waiting for the next DMA Activate
    DRAIN     // transfer failed/aborted, discarding the rest of the stream
  } state_t;

  // Header dword of a Data FIS: only the type byte is non-zero.
  function automatic logic [31:0] data_fis_header();
    return {24'h0, FIS_DATA};
  endfunction

endpackage

// File: rtl/satatrn_txdata_sched.sv
// Splits one host write transfer into Data FISes, each gated by a DMA
// Activate from the device, and feeds them to the transport TX arbiter.
module satatrn_txdata_sched
  import satatrn_pkg::*;
#(
  parameter int LGMAXFIS     = 11,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic        i_phy_clk,
  input  logic        i_phy_reset_n,
  input  logic        i_abort,
  input  logic        i_clear_err,
  input  logic        i_dma_activate,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  input  logic [31:0] i_s_data,
  input  logic        i_s_last,
  output logic        o_m_valid,
  input  logic        i_m_ready,
  output logic [31:0] o_m_data,
  output logic        o_m_last,
  input  logic        i_link_done,
  input  logic        i_link_err,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_fis_count
);

  state_t              r_state;
  logic                r_m_valid;
  logic [31:0]         r_m_data;
  logic                r_m_last;
  logic                r_act_pend;
  logic                r_xfer_open;
  logic                r_err;
  logic [LGMAXFIS-1:0] r_cnt;
  logic [15:0]         r_fis_count;

  logic w_adv;
  logic w_s_ready;
  logic w_s_accept;
  logic w_fis_last;
  logic w_hdr_start;
  logic w_err_set;

  // Output register may take a new dword when empty or being drained.
  assign w_adv = !r_m_valid || i_m_ready;

  // An abort cycle never consumes input: the dword presented then must be
  // seen again by DRAIN, otherwise a final dword could be lost and DRAIN
  // would wait forever for a last that already went by.
  assign w_s_ready  = !i_abort &&
                      (((r_state == DATA) && w_adv) || (r_state == DRAIN));
  assign w_s_accept = i_s_valid && w_s_ready;

  // FIS ends on the transfer's last dword or on a full payload; the test
  // uses the pre-increment count so the counter never needs an extra bit.
  assign w_fis_last = i_s_last || (r_cnt == {LGMAXFIS{1'b1}});

  // Header is only issued with data already waiting, so no FIS is empty.
  assign w_hdr_start = ((r_state == IDLE) || (r_state == WAITACT)) &&
                       r_act_pend && i_s_valid && w_adv;

  assign w_err_set = (i_abort && (r_state != IDLE)) ||
                     (i_dma_activate && ((r_state == HDR) || (r_state == DATA))) ||
                     ((r_state == WAIT) && i_link_done && i_link_err);

  // Scheduler FSM with the output register, payload counter and FIS count.
  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
    if (!i_phy_reset_n) begin
      r_state     <= IDLE;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_act_pend  <= 1'b0;
      r_xfer_open <= 1'b0;
      r_cnt       <= '0;
      r_fis_count <= '0;
    end else if (i_abort) begin
      r_m_valid  <= 1'b0;
      r_act_pend <= 1'b0;
      r_state    <= r_xfer_open ? DRAIN : IDLE;
    end else begin
      // An activate during HDR/DATA is a protocol error and is not queued.
      if (i_dma_activate && (r_state != HDR) && (r_state != DATA))
        r_act_pend <= 1'b1;
      // By default the word in the output register is consumed.
      if (w_adv)
        r_m_valid <= 1'b0;
      case (r_state)
        IDLE, WAITACT: begin
          if (w_hdr_start) begin
            r_m_valid   <= 1'b1;
            r_m_data    <= data_fis_header();
            r_m_last    <= 1'b0;
            r_cnt       <= '0;
            r_xfer_open <= 1'b1;
            r_act_pend  <= 1'b0;
            r_state     <= HDR;
          end
        end
        HDR: begin
          if (i_m_ready)
            r_state <= DATA;
        end
        DATA: begin
          if (w_s_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= i_s_data;
            r_m_last  <= w_fis_last;
            r_cnt     <= r_cnt + 1'b1;
            if (w_fis_last) begin
              r_state <= WAIT;
              if (i_s_last)
                r_xfer_open <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (i_link_done) begin
            if (!i_link_err) begin
              r_fis_count <= r_fis_count + 16'd1;
              r_state     <= r_xfer_open ? WAITACT : IDLE;
            end else begin
              r_state     <= r_xfer_open ? DRAIN : IDLE;
            end
          end
        end
        DRAIN: begin
          if (i_s_valid && i_s_last) begin
            r_state     <= IDLE;
            r_xfer_open <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky error flag; a new error in the same cycle beats a clear.
  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
    if (!i_phy_reset_n)
      r_err <= 1'b0;
    else if (w_err_set)
      r_err <= 1'b1;
    else if (i_clear_err)
      r_err <= 1'b0;
  end

  assign o_s_ready   = w_s_ready;
  assign o_m_valid   = r_m_valid;
  assign o_m_data    = (OPT_LOWPOWER && !r_m_valid) ? 32'h0 : r_m_data;
  assign o_m_last    = (OPT_LOWPOWER && !r_m_valid) ? 1'b0  : r_m_last;
  assign o_busy      = (r_state != IDLE);
  assign o_err       = r_err;
  assign o_fis_count = r_fis_count;

endmodule

// File: tb/tb_satatrn_txdata_sched.sv
// Self-checking bench for satatrn_txdata_sched (small FIS size, low-power on).
module tb_satatrn_txdata_sched;

  localparam int LG    = 2;
  localparam int MAXPL = 1 << LG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_abort = 1'b0, i_clear_err = 1'b0, i_dma_activate = 1'b0;
  logic        i_s_valid = 1'b0, i_s_last = 1'b0, i_m_ready = 1'b0;
  logic [31:0] i_s_data = '0;
  logic        i_link_done = 1'b0, i_link_err = 1'b0;
  logic        o_s_ready, o_m_valid, o_m_last, o_busy, o_err;
  logic [31:0] o_m_data;
  logic [15:0] o_fis_count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_fis = '0;

  always #5 clk = ~clk;

  satatrn_txdata_sched #(.LGMAXFIS(LG), .OPT_LOWPOWER(1'b1)) dut (
    .i_phy_clk(clk), .i_phy_reset_n(rst_n), .i_abort(i_abort),
    .i_clear_err(i_clear_err), .i_dma_activate(i_dma_activate),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
    .i_s_last(i_s_last), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
    .o_m_data(o_m_data), .o_m_last(o_m_last), .i_link_done(i_link_done),
    .i_link_err(i_link_err), .o_busy(o_busy), .o_err(o_err),
    .o_fis_count(o_fis_count)
  );

  typedef struct {
    logic act, sv; logic [31:0] sd; logic sl, mr, ld;
    logic e_mv; logic [31:0] e_md; logic e_ml, e_sr, e_busy, e_err;
    logic [15:0] e_cnt;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] dw(input int i);
    return 32'h1111_0000 + 32'(i);
  endfunction

  task automatic idle_inputs();
    i_abort = 0; i_clear_err = 0; i_dma_activate = 0; i_s_valid = 0;
    i_s_last = 0; i_s_data = '0; i_m_ready = 1; i_link_done = 0; i_link_err = 0;
  endtask

  // One host transfer of n dwords; the bench plays device and link.
  task automatic run_xfer(input string tag, input int n, input bit rnd, input int act_delay,
                          input bit lerr, input int abort_at, input logic [31:0] base);
    logic [31:0] q_data[$];
    logic        q_last[$];
    int in_idx = 0, hdrs = 0, acts = 0, dones_ok = 0, act_cyc = 0;
    int act_timer = act_delay, done_timer = -1;
    bit aborted = 0, errd = 0, stalled = 0, first_seen = 0, finished = 0;
    logic [31:0] held = '0;
    for (int off = 0; off < n; off += MAXPL) begin
      int chunk;
      chunk = (n - off < MAXPL) ? n - off : MAXPL;
      q_data.push_back(32'h46); q_last.push_back(1'b0);
      for (int j = 0; j < chunk; j++) begin
        q_data.push_back(base + 32'(off + j));
        q_last.push_back(j == chunk - 1);
      end
    end
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      i_dma_activate = (act_timer == 0);
      if (act_timer >= 0) act_timer--;
      i_link_done = (done_timer == 0);
      i_link_err  = i_link_done && lerr && !errd;
      if (done_timer >= 0) done_timer--;
      i_abort   = (abort_at >= 0) && !aborted && (in_idx == abort_at);
      i_s_valid = (in_idx < n);
      i_s_data  = base + 32'(in_idx);
      i_s_last  = (in_idx == n - 1);
      i_m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (aborted || errd) begin
        check({tag, "_no_output_after_stop"}, 64'(o_m_valid), 64'(0));
        if (in_idx < n) check({tag, "_drain_ready"}, 64'(o_s_ready), 64'(1));
        stalled = 0;
      end else begin
        if (stalled) begin
          check({tag, "_stall_valid"}, 64'(o_m_valid), 64'(1));
          check({tag, "_stall_data"}, 64'(o_m_data), 64'(held));
        end
        if (acts == 0) check({tag, "_no_hdr_before_act"}, 64'(o_m_valid), 64'(0));
        if (act_delay > 0 && o_m_valid && !first_seen) begin
          first_seen = 1;
          check({tag, "_act_to_hdr_cycles"}, 64'(cyc - act_cyc), 64'(2));
        end
        if (o_m_valid && i_m_ready) begin
          if (q_data.size() == 0) fail_now({tag, "_extra_output"});
          else begin
            logic [31:0] ed;
            logic        el;
            ed = q_data.pop_front();
            el = q_last.pop_front();
            check({tag, "_out_data"}, 64'(o_m_data), 64'(ed));
            check({tag, "_out_last"}, 64'(o_m_last), 64'(el));
            if (ed == 32'h46) begin
              check({tag, "_hdr_after_act"}, 64'(acts > hdrs), 64'(1));
              check({tag, "_hdr_after_done"}, 64'(dones_ok >= hdrs), 64'(1));
              hdrs++;
            end
          end
          if (o_m_last) done_timer = 3;
        end
        stalled = o_m_valid && !i_m_ready;
        held    = o_m_data;
      end
      if (i_dma_activate) begin acts++; act_cyc = cyc; end
      if (i_link_done) begin
        if (i_link_err) errd = 1;
        else begin
          dones_ok++;
          exp_fis++;
          if (q_data.size() > 0) act_timer = 2;
        end
      end
      if (i_abort) aborted = 1;
      if (i_s_valid && o_s_ready) in_idx++;
      finished = (in_idx == n) && !o_busy && (done_timer < 0) && (act_timer < 0) && (cyc > 0);
    end
    if (!finished) fail_now({tag, "_timeout"});
    @(negedge clk);
    idle_inputs();
    #1;
    if (!lerr && abort_at < 0) check({tag, "_outputs_left"}, 64'(q_data.size()), 64'(0));
    check({tag, "_fis_count"}, 64'(o_fis_count), 64'(exp_fis));
    check({tag, "_busy_end"}, 64'(o_busy), 64'(0));
    check({tag, "_err_end"}, 64'(o_err), 64'(lerr || (abort_at >= 0)));
    $display("xfer %s: n=%0d words_in=%0d headers=%0d fis_ok=%0d err=%0b", tag, n, in_idx, hdrs, dones_ok, o_err);
  endtask

  task automatic clear_error(input string tag);
    @(negedge clk); i_clear_err = 1;
    @(negedge clk); i_clear_err = 0;
    #1;
    check({tag, "_err_cleared"}, 64'(o_err), 64'(0));
  endtask

  // Bounded run time regardless of DUT behaviour.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vec[10];
    vec[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vec[1] = '{1'b0, 1'b1, dw(0),  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vec[2] = '{1'b0, 1'b1, dw(0),  1'b0, 1'b1, 1'b0, 1'b1, 32'h46, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vec[3] = '{1'b0, 1'b1, dw(0),  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vec[4] = '{1'b0, 1'b1, dw(1),  1'b0, 1'b1, 1'b0, 1'b1, dw(0),  1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vec[5] = '{1'b0, 1'b1, dw(2),  1'b0, 1'b1, 1'b0, 1'b1, dw(1),  1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vec[6] = '{1'b0, 1'b1, dw(3),  1'b1, 1'b1, 1'b0, 1'b1, dw(2),  1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vec[7] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, dw(3),  1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vec[8] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vec[9] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 64'({o_m_valid, o_m_data, o_m_last, o_s_ready, o_busy, o_err, o_fis_count}), 64'(0));
    @(negedge clk);
    rst_n = 1;

    // Cycle-exact 4-dword transfer.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_dma_activate = vec[i].act; i_s_valid = vec[i].sv; i_s_data = vec[i].sd;
      i_s_last = vec[i].sl; i_m_ready = vec[i].mr; i_link_done = vec[i].ld; i_link_err = 1'b0;
      #1;
      check($sformatf("vec%0d", i),
            64'({o_m_valid, o_m_data, o_m_last, o_s_ready, o_busy, o_err, o_fis_count}),
            64'({vec[i].e_mv, vec[i].e_md, vec[i].e_ml, vec[i].e_sr, vec[i].e_busy, vec[i].e_err, vec[i].e_cnt}));
      $display("vec %0d: mv=%0b md=%08h ml=%0b sr=%0b busy=%0b cnt=%0d", i, o_m_valid, o_m_data, o_m_last, o_s_ready, o_busy, o_fis_count);
    end
    exp_fis = 16'd1;
    idle_inputs();

    run_xfer("split10", 10, 1'b0, 0,   1'b0, -1, 32'h2222_0000);
    run_xfer("noact",    8, 1'b0, 100, 1'b0, -1, 32'h3333_0000);
    run_xfer("rndready",16, 1'b1, 0,   1'b0, -1, 32'h4444_0000);
    run_xfer("linkerr", 10, 1'b0, 0,   1'b1, -1, 32'h5555_0000);
    clear_error("linkerr");
    run_xfer("abort",    8, 1'b0, 0,   1'b0,  2, 32'h6666_0000);
    clear_error("abort");
    run_xfer("fresh",    5, 1'b0, 0,   1'b0, -1, 32'h7777_0000);

    // Abort while idle with nothing open must not raise an error.
    @(negedge clk); i_abort = 1;
    @(negedge clk); i_abort = 0;
    #1;
    check("idle_abort_err", 64'(o_err), 64'(0));
    check("idle_abort_busy", 64'(o_busy), 64'(0));
    $display("idle abort: err=%0b busy=%0b", o_err, o_busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
